// File: rtl/line_pkg.sv
// ============================================================================
// line_pkg: shared state encoding and geometry constants for line drawing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package line_pkg;

    localparam int LINE_COORD_W = 10;
    localparam int LINE_COLOR_W = 8;
    localparam int LINE_H_RES   = 640;
    localparam int LINE_V_RES   = 480;

    // Signed width for dx/dy/err; doubling err needs one more bit.
    function automatic int err_width(input int coord_w);
        return coord_w + 2;
    endfunction

    localparam int LINE_ERR_W = err_width(LINE_COORD_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2
    } line_state_t;

endpackage

`default_nettype wire

// File: rtl/line_clip_check.sv
// ============================================================================
// line_clip_check: combinational test of a pixel against the visible area.
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_clip_check #(
    parameter int COORD_W = 10,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               on_screen
);

    localparam logic [31:0] H_LIM = 32'(H_RES);
    localparam logic [31:0] V_LIM = 32'(V_RES);

    assign on_screen = (32'(x) < H_LIM) && (32'(y) < V_LIM);

endmodule

`default_nettype wire

// File: rtl/line_rasterizer.sv
// ============================================================================
// line_rasterizer: Bresenham segment walker streaming one clipped pixel/cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_rasterizer
    import line_pkg::*;
#(
    parameter int COORD_W = LINE_COORD_W,
    parameter int H_RES   = LINE_H_RES,
    parameter int V_RES   = LINE_V_RES,
    parameter int COLOR_W = LINE_COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic [COORD_W-1:0] cmd_x2,
    input  logic [COORD_W-1:0] cmd_y2,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [COLOR_W-1:0] px_color,
    output logic               px_last,
    output logic               busy,
    output logic               done
);

    localparam int EW = err_width(COORD_W);

    line_state_t state, state_nxt;

    logic [COORD_W-1:0] start_x, start_y, end_x, end_y;
    logic [COORD_W-1:0] cur_x_nxt, cur_y_nxt;
    logic signed [EW-1:0] dx, dy, err, err_nxt;
    logic sx_neg, sy_neg, done_nxt;

    logic [COORD_W-1:0]   abs_dx, abs_dy, x_adv, y_adv;
    logic signed [EW-1:0] setup_dx, setup_dy;
    logic signed [EW:0]   e2, dx_ext, dy_ext;
    logic step_x, step_y, at_end, advance, nxt_on_screen;

    assign abs_dx   = (end_x >= start_x) ? (end_x - start_x) : (start_x - end_x);
    assign abs_dy   = (end_y >= start_y) ? (end_y - start_y) : (start_y - end_y);
    assign setup_dx = $signed({2'b00, abs_dx});
    assign setup_dy = -$signed({2'b00, abs_dy});

    assign e2     = {err, 1'b0};
    assign dx_ext = {dx[EW-1], dx};
    assign dy_ext = {dy[EW-1], dy};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);
    assign x_adv  = sx_neg ? (px_x - COORD_W'(1)) : (px_x + COORD_W'(1));
    assign y_adv  = sy_neg ? (px_y - COORD_W'(1)) : (px_y + COORD_W'(1));
    assign at_end = (px_x == end_x) && (px_y == end_y);

    // px_valid is registered as on_screen(cur), so a clipped pixel has
    // px_valid low and is skipped without waiting for px_ready.
    assign advance = (state == STEP) && (!px_valid || px_ready);

    always_comb begin
        state_nxt = state;
        cur_x_nxt = px_x;
        cur_y_nxt = px_y;
        err_nxt   = err;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = STEP;
                cur_x_nxt = start_x;
                cur_y_nxt = start_y;
                err_nxt   = setup_dx + setup_dy;
            end
            STEP: begin
                if (advance) begin
                    if (at_end) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        if (step_x) begin
                            cur_x_nxt = x_adv;
                        end
                        if (step_y) begin
                            cur_y_nxt = y_adv;
                        end
                        err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    line_clip_check #(
        .COORD_W (COORD_W),
        .H_RES   (H_RES),
        .V_RES   (V_RES)
    ) u_clip (
        .x         (cur_x_nxt),
        .y         (cur_y_nxt),
        .on_screen (nxt_on_screen)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            start_x   <= '0;
            start_y   <= '0;
            end_x     <= '0;
            end_y     <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            sx_neg    <= 1'b0;
            sy_neg    <= 1'b0;
            px_x      <= '0;
            px_y      <= '0;
            px_color  <= '0;
            px_valid  <= 1'b0;
            px_last   <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            px_x  <= cur_x_nxt;
            px_y  <= cur_y_nxt;
            err   <= err_nxt;
            if (state == IDLE && cmd_valid) begin
                start_x  <= cmd_x1;
                start_y  <= cmd_y1;
                end_x    <= cmd_x2;
                end_y    <= cmd_y2;
                px_color <= cmd_color;
            end
            if (state == SETUP) begin
                dx     <= setup_dx;
                dy     <= setup_dy;
                sx_neg <= (end_x < start_x);
                sy_neg <= (end_y < start_y);
            end
            px_valid  <= (state_nxt == STEP) && nxt_on_screen;
            px_last   <= (state_nxt == STEP) && nxt_on_screen &&
                         (cur_x_nxt == end_x) && (cur_y_nxt == end_y);
            busy      <= (state_nxt != IDLE);
            cmd_ready <= (state_nxt == IDLE);
            done      <= done_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_rasterizer.sv
// ============================================================================
// tb_line_rasterizer: directed self-checking bench for line_rasterizer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_line_rasterizer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_x1 = '0, cmd_y1 = '0, cmd_x2 = '0, cmd_y2 = '0;
    logic [7:0] cmd_color = '0;
    logic       px_valid;
    logic       px_ready = 1'b0;
    logic [9:0] px_x, px_y;
    logic [7:0] px_color;
    logic       px_last, busy, done;

    int checks = 0;
    int failures = 0;

    logic [9:0] got_x [64];
    logic [9:0] got_y [64];
    logic       got_last [64];
    logic [7:0] got_c [64];
    int npx, nlast, first_cyc, done_cyc, hold_err;
    logic ready_at_done;

    always #5 clk = ~clk;

    line_rasterizer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_x2    (cmd_x2),
        .cmd_y2    (cmd_y2),
        .cmd_color (cmd_color),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_color  (px_color),
        .px_last   (px_last),
        .busy      (busy),
        .done      (done)
    );

    // Issues one command at a negedge and collects accepted pixels.
    // Cycle 1 is the cycle after the accepting edge; pat gives px_ready
    // per px_valid cycle, then ready stays high.
    task automatic run_line(input logic [9:0] x1, input logic [9:0] y1,
                            input logic [9:0] x2, input logic [9:0] y2,
                            input logic [7:0] col, input logic [7:0] pat,
                            input int pat_len);
        logic       stalled;
        logic [9:0] hx, hy;
        logic       hl;
        int         k;
        stalled = 1'b0; hx = '0; hy = '0; hl = 1'b0; k = 0;
        npx = 0; nlast = 0; first_cyc = -1; done_cyc = -1; hold_err = 0;
        ready_at_done = 1'b0;
        cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2; cmd_color = col;
        cmd_valid = 1'b1;
        px_ready  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                ready_at_done = cmd_ready;
                break;
            end
            if (stalled && (!px_valid || px_x !== hx || px_y !== hy || px_last !== hl))
                hold_err++;
            if (px_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                px_ready = (k < pat_len) ? pat[k] : 1'b1;
                k++;
                if (px_ready && npx < 64) begin
                    got_x[npx] = px_x;
                    got_y[npx] = px_y;
                    got_last[npx] = px_last;
                    got_c[npx] = px_color;
                    if (px_last) nlast++;
                    npx++;
                end
                stalled = !px_ready;
                hx = px_x; hy = px_y; hl = px_last;
            end else begin
                px_ready = 1'b0;
                stalled = 1'b0;
            end
            @(negedge clk);
        end
        px_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({cmd_ready, px_valid, px_last, busy, done} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 10000",
                     {cmd_ready, px_valid, px_last, busy, done});
        end
        checks++;
        if ({px_x, px_y, px_color} !== 28'd0) begin
            failures++;
            $display("FAIL reset_data: got x=%0d y=%0d c=%0h expected 0/0/0", px_x, px_y, px_color);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_horizontal();
        int ex[4] = '{0, 1, 2, 3};
        run_line(10'd0, 10'd0, 10'd3, 10'd0, 8'h5A, 8'h00, 0);
        checks++;
        if (npx !== 4) begin
            failures++; $display("FAIL horiz_count: got %0d expected 4", npx);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_x[i] !== 10'(ex[i]) || got_y[i] !== 10'd0 || got_last[i] !== (i == 3)) begin
                    failures++;
                    $display("FAIL horiz_px%0d: got (%0d,%0d,last=%b) expected (%0d,0,last=%b)",
                             i, got_x[i], got_y[i], got_last[i], ex[i], (i == 3));
                end
            end
            checks++;
            if (got_c[0] !== 8'h5A) begin
                failures++; $display("FAIL horiz_color: got %0h expected 5a", got_c[0]);
            end
        end
        checks++;
        if (first_cyc !== 2) begin
            failures++; $display("FAIL horiz_first: got cycle %0d expected 2", first_cyc);
        end
        checks++;
        if (done_cyc !== 6 || ready_at_done !== 1'b1) begin
            failures++;
            $display("FAIL horiz_done: got cycle %0d ready=%b expected 6 ready=1", done_cyc, ready_at_done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL horiz_done_pulse: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_diag_neg();
        int ex[4] = '{5, 4, 3, 2};
        run_line(10'd5, 10'd5, 10'd2, 10'd2, 8'h11, 8'h00, 0);
        checks++;
        if (npx !== 4 || nlast !== 1) begin
            failures++; $display("FAIL diag_count: got %0d last=%0d expected 4 last=1", npx, nlast);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_x[i] !== 10'(ex[i]) || got_y[i] !== 10'(ex[i])) begin
                    failures++;
                    $display("FAIL diag_px%0d: got (%0d,%0d) expected (%0d,%0d)",
                             i, got_x[i], got_y[i], ex[i], ex[i]);
                end
            end
        end
    endtask

    task automatic test_steep();
        int ex_x[4] = '{0, 0, 1, 1};
        int ex_y[4] = '{0, 1, 2, 3};
        run_line(10'd0, 10'd0, 10'd1, 10'd3, 8'h22, 8'h00, 0);
        checks++;
        if (npx !== 4) begin
            failures++; $display("FAIL steep_count: got %0d expected 4", npx);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_x[i] !== 10'(ex_x[i]) || got_y[i] !== 10'(ex_y[i])) begin
                    failures++;
                    $display("FAIL steep_px%0d: got (%0d,%0d) expected (%0d,%0d)",
                             i, got_x[i], got_y[i], ex_x[i], ex_y[i]);
                end
            end
        end
    endtask

    task automatic test_degenerate();
        run_line(10'd7, 10'd9, 10'd7, 10'd9, 8'h33, 8'h00, 0);
        checks++;
        if (npx !== 1 || got_x[0] !== 10'd7 || got_y[0] !== 10'd9 || got_last[0] !== 1'b1) begin
            failures++;
            $display("FAIL degen_px: got n=%0d (%0d,%0d,last=%b) expected n=1 (7,9,last=1)",
                     npx, got_x[0], got_y[0], got_last[0]);
        end
        checks++;
        if (done_cyc !== 3) begin
            failures++; $display("FAIL degen_done: got cycle %0d expected 3", done_cyc);
        end
    endtask

    task automatic test_back_to_back_stall();
        // px_ready sequence 0,0,1,0,1,1,1 from the first px_valid
        run_line(10'd0, 10'd0, 10'd3, 10'd0, 8'h44, 8'h74, 7);
        checks++;
        if (hold_err !== 0) begin
            failures++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", hold_err);
        end
        checks++;
        if (npx !== 4 || nlast !== 1) begin
            failures++; $display("FAIL stall_count: got %0d last=%0d expected 4 last=1", npx, nlast);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_x[i] !== 10'(i) || got_y[i] !== 10'd0) begin
                    failures++;
                    $display("FAIL stall_px%0d: got (%0d,%0d) expected (%0d,0)", i, got_x[i], got_y[i], i);
                end
            end
        end
        checks++;
        if (first_cyc !== 2 || done_cyc !== 9) begin
            failures++;
            $display("FAIL stall_timing: got first=%0d done=%0d expected first=2 done=9", first_cyc, done_cyc);
        end
    endtask

    task automatic test_clip();
        run_line(10'd638, 10'd10, 10'd642, 10'd10, 8'h55, 8'h00, 0);
        checks++;
        if (npx !== 2 || got_x[0] !== 10'd638 || got_x[1] !== 10'd639 ||
            got_y[0] !== 10'd10 || got_y[1] !== 10'd10) begin
            failures++;
            $display("FAIL clip_px: got n=%0d (%0d,%0d) (%0d,%0d) expected n=2 (638,10) (639,10)",
                     npx, got_x[0], got_y[0], got_x[1], got_y[1]);
        end
        checks++;
        if (nlast !== 0) begin
            failures++; $display("FAIL clip_last: got %0d px_last expected 0", nlast);
        end
        checks++;
        if (first_cyc !== 2 || done_cyc !== 7) begin
            failures++;
            $display("FAIL clip_done: got first=%0d done=%0d expected first=2 done=7", first_cyc, done_cyc);
        end
    endtask

    task automatic test_reset_midline();
        cmd_x1 = 10'd0; cmd_y1 = 10'd0; cmd_x2 = 10'd20; cmd_y2 = 10'd0; cmd_color = 8'h66;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        px_ready  = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (px_valid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL midline_active: got valid=%b busy=%b expected 1/1", px_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({px_valid, busy, done, cmd_ready, px_last} !== 5'b00010 || px_x !== 10'd0) begin
            failures++;
            $display("FAIL midline_rst: got v/b/d/r/l=%b x=%0d expected 00010 x=0",
                     {px_valid, busy, done, cmd_ready, px_last}, px_x);
        end
        px_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midline_idle: got done=%b busy=%b ready=%b expected 0/0/1", done, busy, cmd_ready);
        end
        run_line(10'd10, 10'd2, 10'd12, 10'd2, 8'h77, 8'h00, 0);
        checks++;
        if (npx !== 3 || got_x[0] !== 10'd10 || got_x[2] !== 10'd12 || got_y[1] !== 10'd2 ||
            got_last[2] !== 1'b1 || got_c[0] !== 8'h77 || done_cyc !== 5) begin
            failures++;
            $display("FAIL midline_fresh: got n=%0d x0=%0d x2=%0d last=%b c=%0h done=%0d expected 3 10 12 1 77 5",
                     npx, got_x[0], got_x[2], got_last[2], got_c[0], done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_diag_neg();
        test_steep();
        test_degenerate();
        test_back_to_back_stall();
        test_clip();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
